// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder types and defaults.
package viterbi_pkg;
  localparam int DEF_NUM_PAIRS = 8;
  localparam int PAIR_W        = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    TB_WAIT,
    RELEASE
  } seq_state_t;
endpackage

// File: rtl/decode_sequencer.sv
// Frame sequencer: captures a frame, feeds its symbol pairs to the ACS datapath, runs traceback, releases the buffer.
// Latency: first pair visible 2 cycles after the LOAD cycle; outputs are registered, so each reacts one cycle after its cause.
// Backpressure: hold stalls the pair feed; traceback waits for tb_done, bounded by TB_TIMEOUT.
module decode_sequencer
  import viterbi_pkg::*;
#(
  parameter int NUM_PAIRS  = DEF_NUM_PAIRS,
  parameter int TB_TIMEOUT = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [PAIR_W*NUM_PAIRS-1:0]                 frame_in,
  input  logic                                        frame_valid,
  input  logic                                        hold,
  input  logic                                        tb_done,
  output logic                                        refresh,
  output logic                                        acs_clear,
  output logic [PAIR_W-1:0]                           pair_out,
  output logic                                        pair_valid,
  output logic [((NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1)-1:0] step_idx,
  output logic                                        tb_start,
  output logic                                        busy,
  output logic                                        tb_err,
  output logic [7:0]                                  frame_cnt
);

  localparam int FRAME_W = PAIR_W * NUM_PAIRS;
  localparam int STEP_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int TMR_W   = (TB_TIMEOUT > 1) ? $clog2(TB_TIMEOUT) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_PAIRS - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TB_TIMEOUT - 1);

  seq_state_t          state;
  logic [FRAME_W-1:0]  frame_q;
  logic [STEP_W-1:0]   step_cnt;
  logic [TMR_W-1:0]    tmr;
  logic [FRAME_W-1:0]  frame_sh;
  logic [PAIR_W-1:0]   pair_sel;

  // Pair 0 lives in the MSBs, so shift the selected pair up to the top.
  always_comb begin
    frame_sh = frame_q << (PAIR_W * step_cnt);
    pair_sel = frame_sh[FRAME_W-1 -: PAIR_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      frame_q    <= '0;
      step_cnt   <= '0;
      tmr        <= '0;
      refresh    <= 1'b0;
      acs_clear  <= 1'b0;
      pair_out   <= '0;
      pair_valid <= 1'b0;
      step_idx   <= '0;
      tb_start   <= 1'b0;
      busy       <= 1'b0;
      tb_err     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      refresh   <= 1'b0;
      acs_clear <= 1'b0;
      tb_start  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_valid) begin
            frame_q   <= frame_in;
            state     <= LOAD;
            busy      <= 1'b1;
            acs_clear <= 1'b1;
            step_cnt  <= '0;
            step_idx  <= '0;
          end
        end
        LOAD: state <= FEED;
        FEED: begin
          if (hold) begin
            pair_valid <= 1'b0;
          end else begin
            pair_valid <= 1'b1;
            pair_out   <= pair_sel;
            step_idx   <= step_cnt;
            step_cnt   <= step_cnt + 1'b1;
            if (step_cnt == LAST_STEP) begin
              state    <= TB_WAIT;
              tb_start <= 1'b1;
              tmr      <= '0;
            end
          end
        end
        TB_WAIT: begin
          pair_valid <= 1'b0;
          // tb_start is still high in the first TB_WAIT cycle, masking tb_done there.
          if (!tb_start && tb_done) begin
            state     <= RELEASE;
            refresh   <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end else if (tmr == TMR_LAST) begin
            state     <= RELEASE;
            refresh   <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
            tb_err    <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Randomized bench for decode_sequencer with a frame-level reference model and per-cycle output checks.
module tb_decode_sequencer;
  localparam int NP = 8;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic        hold = 1'b0;
  logic        tb_done = 1'b0;
  logic        refresh, acs_clear, pair_valid, tb_start, busy, tb_err;
  logic [1:0]  pair_out;
  logic [2:0]  step_idx;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  decode_sequencer #(.NUM_PAIRS(NP), .TB_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_in   (frame_in),
    .frame_valid(frame_valid),
    .hold       (hold),
    .tb_done    (tb_done),
    .refresh    (refresh),
    .acs_clear  (acs_clear),
    .pair_out   (pair_out),
    .pair_valid (pair_valid),
    .step_idx   (step_idx),
    .tb_start   (tb_start),
    .busy       (busy),
    .tb_err     (tb_err),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    int pair;
    int step;
  } exp_t;

  exp_t exp_q[$];
  int   seen_pairs[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;
  bit   exp_err = 1'b0;
  int   last_pair = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tmo(input string name);
    n_chk++;
    $display("FAIL %s: wait bound expired, event not seen, expected it", name);
  endtask

  // Pair k of a frame, counting from the MSB end.
  function automatic int model_pair(input logic [15:0] f, input int k);
    return int'((f >> (2 * (NP - 1 - k))) & 16'h3);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_refresh"},    refresh,    0);
    chk({tag, "_acs_clear"},  acs_clear,  0);
    chk({tag, "_pair_out"},   pair_out,   0);
    chk({tag, "_pair_valid"}, pair_valid, 0);
    chk({tag, "_step_idx"},   step_idx,   0);
    chk({tag, "_tb_start"},   tb_start,   0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_tb_err"},     tb_err,     0);
    chk({tag, "_frame_cnt"},  frame_cnt,  0);
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (!rst) begin
      last_pair = 0;
    end else begin
      chk("pulse_excl", {refresh, acs_clear, tb_start} inside {3'b000, 3'b001, 3'b010, 3'b100}, 1);
      if (pair_valid) begin
        chk("valid_busy", busy, 1);
        seen_pairs.push_back(int'(pair_out));
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL pair_unexpected: got pair_valid=1 pair_out=%0d, expected no pair", pair_out);
        end else begin
          e = exp_q.pop_front();
          chk("pair_out", pair_out, e.pair);
          chk("step_idx", step_idx, e.step);
        end
        last_pair = int'(pair_out);
      end else begin
        chk("pair_hold", pair_out, last_pair);
      end
      if (refresh) chk("pairs_issued", exp_q.size(), 0);
    end
  end

  // d: cycles after tb_start at which tb_done pulses (0 = never).
  task automatic run_frame(input logic [15:0] f, input int hold_pct, input int d,
                           input bit stall3, output int lat);
    int n, c, nvalid, hold_cnt, stall_chk, exp_lat;
    bit seen, exp_tmo;
    frame_in    = f;
    frame_valid = 1'b1;
    hold        = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!acs_clear && n < 20);
    lat = n;
    if (!acs_clear) begin
      tmo("acs_clear_wait");
      frame_valid = 1'b0;
      return;
    end
    chk("busy_load", busy, 1);
    chk("step_idx_load", step_idx, 0);
    for (int k = 0; k < NP; k++) exp_q.push_back('{pair: model_pair(f, k), step: k});
    nvalid = 0; hold_cnt = 0; stall_chk = 0; c = 0;
    while (!tb_start && c < 200) begin
      if (c == 1) chk("acs_clear_pulse", acs_clear, 0);
      if (pair_valid) nvalid++;
      if (stall_chk > 0) begin
        chk("stall_valid", pair_valid, 0);
        chk("stall_pair", pair_out, model_pair(f, 3));
        chk("stall_step", step_idx, 3);
        stall_chk--;
      end
      if (stall3 && pair_valid && step_idx == 3'd3) begin
        hold_cnt  = 2;
        stall_chk = 2;
      end
      if (hold_cnt > 0) begin
        hold = 1'b1;
        hold_cnt--;
      end else begin
        hold = stall3 ? 1'b0 : ($urandom_range(0, 99) < hold_pct);
      end
      frame_in    = 16'($urandom);
      frame_valid = 1'($urandom);
      tb_done     = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      c++;
    end
    if (!tb_start) begin
      tmo("tb_start_wait");
      frame_valid = 1'b0;
      return;
    end
    if (pair_valid) nvalid++;
    hold    = 1'b0;
    tb_done = 1'($urandom);
    exp_tmo = (d < 1 || d > TO - 1);
    exp_lat = exp_tmo ? TO : d + 1;
    c = 0; seen = 1'b0;
    while (!seen && c < TO + 8) begin
      @(negedge clk);
      c++;
      if (c == 1) chk("tb_start_pulse", tb_start, 0);
      chk("pair_valid_tb", pair_valid, 0);
      if (refresh) begin
        seen = 1'b1;
      end else begin
        tb_done     = (c == d);
        frame_in    = 16'($urandom);
        frame_valid = 1'($urandom);
      end
    end
    if (!seen) begin
      tmo("refresh_wait");
    end else begin
      exp_cnt++;
      exp_err = exp_err | exp_tmo;
      chk("refresh_lat", c, exp_lat);
      chk("frame_cnt", frame_cnt, exp_cnt % 256);
      chk("tb_err", tb_err, exp_err);
      chk("busy_release", busy, 1);
      chk("valid_pairs", nvalid, NP);
    end
    tb_done     = 1'b0;
    frame_valid = 1'b0;
    hold        = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time bound expired, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, gap;
    int lit_pairs[8];
    lit_pairs = '{2, 3, 0, 1, 3, 2, 1, 0};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single frame with tb_done 3 cycles after tb_start.
    seen_pairs.delete();
    run_frame(16'hB1E4, 0, 3, 1'b0, lat);
    chk("single_npairs", seen_pairs.size(), 8);
    for (int k = 0; k < 8 && k < seen_pairs.size(); k++) chk("single_pair_lit", seen_pairs[k], lit_pairs[k]);
    chk("single_frame_cnt", frame_cnt, 1);

    // Two-cycle stall while step 3 is on the output.
    repeat (2) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
    end
    run_frame(16'h6C93, 0, 5, 1'b1, lat);

    // Back-to-back frames.
    run_frame(16'h1234, 20, 2, 1'b0, lat);
    run_frame(16'hFEDC, 20, 4, 1'b0, lat);
    chk("b2b_load_gap", lat, 2);
    chk("b2b_frame_cnt", frame_cnt, 4);

    // tb_done on the last timeout cycle counts as success.
    run_frame(16'h0F0F, 0, TO - 1, 1'b0, lat);
    chk("coincide_tb_err", tb_err, 0);

    // Reset in the middle of FEED.
    @(negedge clk);
    frame_in    = 16'hA55A;
    frame_valid = 1'b1;
    hold        = 1'b0;
    for (int k = 0; k < NP; k++) exp_q.push_back('{pair: model_pair(16'hA55A, k), step: k});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pair_valid && step_idx == 3'd5) && n < 40);
    if (!(pair_valid && step_idx == 3'd5)) tmo("step5_wait");
    #1 rst = 1'b0;
    #1;
    check_zero("midrst");
    exp_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_refresh", refresh, 0);
      chk("midrst_busy", busy, 0);
    end
    rst = 1'b1;
    run_frame(16'hA55A, 10, 2, 1'b0, lat);
    chk("midrst_redo_cnt", frame_cnt, 1);

    // Frame counter wrap with idle gaps and stray tb_done.
    for (int i = 0; i < 255; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        frame_valid = 1'b0;
        tb_done     = 1'($urandom);
        @(negedge clk);
        chk("idle_busy", busy, 0);
      end
      tb_done = 1'b0;
      run_frame(16'($urandom), 25, $urandom_range(1, 20), 1'b0, lat);
    end
    chk("wrap_frame_cnt", frame_cnt, 0);

    // Traceback timeout, then sticky error through a good frame.
    run_frame(16'hC3A5, 10, 0, 1'b0, lat);
    chk("timeout_tb_err", tb_err, 1);
    run_frame(16'h5A3C, 10, 2, 1'b0, lat);
    chk("sticky_tb_err", tb_err, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
